// File: rtl/slc3_datapath_mem.sv
// SLC-3 datapath: PC/IR/MAR/MDR, 8-entry register file, CC/BEN on one shared bus,
// plus a request/acknowledge memory engine with wait states, timeout and sticky error.
module slc3_datapath_mem #(
    parameter int          WIDTH       = 16,
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_pc,
    input  logic             ld_mar,
    input  logic             ld_mdr,
    input  logic             ld_ir,
    input  logic             ld_reg,
    input  logic             ld_cc,
    input  logic [2:0]       gate_sel,
    input  logic [1:0]       pc_sel,
    input  logic             addr1_sel,
    input  logic [1:0]       addr2_sel,
    input  logic             sr1_sel,
    input  logic             dr_sel,
    input  logic [1:0]       aluop,
    input  logic             mem_rd,
    input  logic             mem_wr,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             mem_busy,
    output logic             mem_done,
    output logic             mem_err,
    output logic [WIDTH-1:0] ir_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] mar_out,
    output logic [WIDTH-1:0] mdr_out,
    output logic [WIDTH-1:0] bus_out,
    output logic [2:0]       cc_out,
    output logic             ben
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WIDTH-1:0] PC_INIT = WIDTH'(RESET_PC);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_state_t;

    logic [WIDTH-1:0]        pc, ir, mar, mdr;
    logic [7:0][WIDTH-1:0]   regs;
    logic [2:0]              cc;
    logic [WIDTH-1:0]        bus, alu, alu_b, sr1, sr2;
    logic [WIDTH-1:0]        addr_a, addr_b, addr_sum, pc_next;
    logic [2:0]              sr1_idx, dr_idx;
    mem_state_t              state;
    logic [CW-1:0]           wait_cnt;
    logic                    rd_done;

    assign sr1_idx = sr1_sel ? ir[11:9] : ir[8:6];
    assign dr_idx  = dr_sel ? 3'd7 : ir[11:9];
    assign sr1     = regs[sr1_idx];
    assign sr2     = regs[ir[2:0]];
    assign alu_b   = ir[5] ? {{(WIDTH-5){ir[4]}}, ir[4:0]} : sr2;

    always_comb begin
        alu = sr1;
        case (aluop)
            2'd0:    alu = sr1 + alu_b;
            2'd1:    alu = sr1 & alu_b;
            2'd2:    alu = ~sr1;
            default: alu = sr1;
        endcase
    end

    assign addr_a = addr1_sel ? sr1 : pc;

    always_comb begin
        addr_b = '0;
        case (addr2_sel)
            2'd1:    addr_b = {{(WIDTH-6){ir[5]}}, ir[5:0]};
            2'd2:    addr_b = {{(WIDTH-9){ir[8]}}, ir[8:0]};
            2'd3:    addr_b = {{(WIDTH-11){ir[10]}}, ir[10:0]};
            default: addr_b = '0;
        endcase
    end

    assign addr_sum = addr_a + addr_b;

    always_comb begin
        bus = '0;
        case (gate_sel)
            3'd1:    bus = pc;
            3'd2:    bus = addr_sum;
            3'd3:    bus = alu;
            3'd4:    bus = mdr;
            default: bus = '0;
        endcase
    end

    always_comb begin
        pc_next = pc;
        case (pc_sel)
            2'd0:    pc_next = pc + WIDTH'(1);
            2'd1:    pc_next = bus;
            2'd2:    pc_next = addr_sum;
            default: pc_next = pc;
        endcase
    end

    // A completing read owns MDR that cycle, even over ld_mdr.
    assign rd_done = (state == RD_WAIT) && mem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc   <= PC_INIT;
            ir   <= '0;
            mar  <= '0;
            mdr  <= '0;
            regs <= '0;
            cc   <= 3'b010;
        end else begin
            if (ld_pc)  pc  <= pc_next;
            if (ld_ir)  ir  <= bus;
            if (ld_mar) mar <= bus;
            if (rd_done)     mdr <= mem_rdata;
            else if (ld_mdr) mdr <= bus;
            if (ld_reg) regs[dr_idx] <= bus;
            if (ld_cc)  cc <= {bus[WIDTH-1], bus == '0, !bus[WIDTH-1] && (bus != '0)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_done  <= 1'b0;
            mem_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
        end else begin
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_rd && mem_wr) begin
                        mem_err <= 1'b1;
                    end else if (mem_rd || mem_wr) begin
                        state     <= mem_wr ? WR_WAIT : RD_WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= mem_wr;
                        mem_addr  <= mar;
                        mem_wdata <= mdr;
                        wait_cnt  <= '0;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_done <= 1'b1;
                    end else if (wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
                        // Last allowed request cycle went unanswered.
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_busy = (state != IDLE);
    assign ir_out   = ir;
    assign pc_out   = pc;
    assign mar_out  = mar;
    assign mdr_out  = mdr;
    assign bus_out  = bus;
    assign cc_out   = cc;
    assign ben      = |(ir[11:9] & cc);

endmodule

// File: tb/tb_slc3_datapath_mem.sv
// Randomized self-checking bench for slc3_datapath_mem against an arithmetic
// register/memory model kept in plain variables.
module tb_slc3_datapath_mem;
    localparam int          W   = 16;
    localparam logic [15:0] RPC = 16'h0200;
    localparam int          TO  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ld_pc, ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc;
    logic [2:0] gate_sel;
    logic [1:0] pc_sel, addr2_sel, aluop;
    logic addr1_sel, sr1_sel, dr_sel, mem_rd, mem_wr, mem_ack;
    logic mem_req, mem_we, mem_busy, mem_done, mem_err, ben;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata, ir_out, pc_out, mar_out, mdr_out, bus_out;
    logic [2:0] cc_out;

    always #5 clk = ~clk;

    slc3_datapath_mem #(.WIDTH(W), .RESET_PC(RPC), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ld_pc(ld_pc), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir),
        .ld_reg(ld_reg), .ld_cc(ld_cc), .gate_sel(gate_sel), .pc_sel(pc_sel),
        .addr1_sel(addr1_sel), .addr2_sel(addr2_sel), .sr1_sel(sr1_sel),
        .dr_sel(dr_sel), .aluop(aluop), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err),
        .ir_out(ir_out), .pc_out(pc_out), .mar_out(mar_out), .mdr_out(mdr_out),
        .bus_out(bus_out), .cc_out(cc_out), .ben(ben)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] m_pc, m_ir, m_mar, m_mdr;
    logic [15:0] m_r [8];
    logic [2:0]  m_cc;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
        logic signed [15:0] t;
        t = $signed(v << (16 - bits));
        return 16'(t >>> (16 - bits));
    endfunction

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'h0)     return 3'b010;
        return 3'b001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {ld_pc, ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc} = '0;
        gate_sel = 3'd0; pc_sel = 2'd0; addr1_sel = 1'b0; addr2_sel = 2'd0;
        sr1_sel = 1'b0; dr_sel = 1'b0; aluop = 2'd0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_pc = RPC; m_ir = '0; m_mar = '0; m_mdr = '0; m_cc = 3'b010; m_err = 1'b0;
        for (int i = 0; i < 8; i++) m_r[i] = '0;
    endtask

    // One access: ack arrives after `waits` unacknowledged request cycles
    // (never if waits >= TO). `poke` retriggers mem_rd and reloads MAR mid-access.
    task automatic mem_access(input bit wr, input int waits, input logic [15:0] rd, input bit poke);
        int nreq, ndone, dcyc;
        logic [15:0] a0, d0;
        bit ok;
        ok = (waits < TO);
        a0 = m_mar; d0 = m_mdr;
        nreq = 0; ndone = 0; dcyc = 0;
        mem_rd = !wr; mem_wr = wr;
        tick();
        mem_rd = 1'b0; mem_wr = 1'b0;
        for (int c = 1; c <= TO + 4; c++) begin
            mem_ack = 1'b0; ld_mar = 1'b0; gate_sel = 3'd0;
            if (mem_done) begin ndone++; dcyc = c; end
            if (mem_req) begin
                chk("mem_addr", mem_addr, a0);
                chk("mem_we", mem_we, wr);
                if (wr) chk("mem_wdata", mem_wdata, d0);
                mem_ack = (nreq == waits);
                mem_rdata = rd;
                nreq++;
                if (poke && c == 1) begin mem_rd = 1'b1; ld_mar = 1'b1; gate_sel = 3'd1; end
            end
            tick();
            mem_rd = 1'b0;
        end
        clr();
        if (poke) m_mar = m_pc;
        if (ok) begin
            if (!wr) m_mdr = rd;
            chk("req_cycles", nreq, waits + 1);
            chk("done_count", ndone, 1);
            chk("done_cycle", dcyc, waits + 2);
        end else begin
            m_err = 1'b1;
            chk("req_cycles_to", nreq, TO);
            chk("done_count_to", ndone, 0);
        end
        chk("mdr", mdr_out, m_mdr);
        chk("mar", mar_out, m_mar);
        chk("mem_err", mem_err, m_err);
        chk("mem_busy_end", mem_busy, 0);
    endtask

    task automatic put_mdr(input logic [15:0] v);
        mem_access(1'b0, 0, v, 1'b0);
    endtask

    task automatic ld_ir_val(input logic [15:0] v);
        put_mdr(v);
        gate_sel = 3'd4; ld_ir = 1'b1;
        tick();
        clr();
        m_ir = v;
        chk("ir", ir_out, m_ir);
    endtask

    task automatic ld_mar_val(input logic [15:0] v);
        put_mdr(v);
        gate_sel = 3'd4; ld_mar = 1'b1;
        tick();
        clr();
        m_mar = v;
    endtask

    task automatic set_reg(input int idx, input logic [15:0] v);
        ld_ir_val({4'h0, 3'(idx), 9'h0});
        put_mdr(v);
        gate_sel = 3'd4; ld_reg = 1'b1;
        tick();
        clr();
        m_r[idx] = v;
    endtask

    task automatic rd_reg(input int idx);
        ld_ir_val({4'h0, 3'(idx), 9'h0});
        gate_sel = 3'd3; aluop = 2'd3; sr1_sel = 1'b1;
        #1;
        chk($sformatf("r%0d", idx), bus_out, m_r[idx]);
        clr();
    endtask

    task automatic alu_exec(input logic [1:0] op);
        logic [15:0] a, b, res;
        a = m_r[m_ir[8:6]];
        b = m_ir[5] ? sx(m_ir, 5) : m_r[m_ir[2:0]];
        case (op)
            2'd0:    res = a + b;
            2'd1:    res = a & b;
            2'd2:    res = ~a;
            default: res = a;
        endcase
        gate_sel = 3'd3; aluop = op; ld_reg = 1'b1; ld_cc = 1'b1;
        #1;
        chk("alu_bus", bus_out, res);
        tick();
        clr();
        m_r[m_ir[11:9]] = res;
        m_cc = cc_of(res);
        chk("alu_cc", cc_out, m_cc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        clr();
        do_reset();

        // Reset state
        chk("rst_pc", pc_out, RPC);
        chk("rst_ir", ir_out, 0);
        chk("rst_mar", mar_out, 0);
        chk("rst_mdr", mdr_out, 0);
        chk("rst_cc", cc_out, 3'b010);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_busy", mem_busy, 0);
        chk("rst_done", mem_done, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ben", ben, 0);
        chk("rst_bus", bus_out, 0);
        for (int i = 0; i < 8; i++) rd_reg(i);

        // ADD immediate, positive and negative
        set_reg(1, 16'd5);
        ld_ir_val(16'h1262);
        alu_exec(2'd0);
        chk("add_cc_pos", cc_out, 3'b001);
        rd_reg(1);
        ld_ir_val(16'h127F);
        alu_exec(2'd0);
        rd_reg(1);

        // Read with three wait states
        ld_mar_val(16'h3000);
        mem_access(1'b0, 3, 16'hBEEF, 1'b0);
        chk("rd_beef", mdr_out, 16'hBEEF);

        // Write that times out, then reset clears the error
        ld_mar_val(16'h4000);
        put_mdr(16'h1234);
        mem_access(1'b1, 99, 16'h0, 1'b0);
        chk("err_sticky", mem_err, 1);
        tick();
        chk("err_sticky2", mem_err, 1);
        do_reset();
        chk("err_cleared", mem_err, 0);

        // Simultaneous rd/wr is illegal
        mem_rd = 1'b1; mem_wr = 1'b1;
        tick();
        clr();
        chk("both_req", mem_req, 0);
        chk("both_busy", mem_busy, 0);
        chk("both_err", mem_err, 1);
        tick();
        chk("both_req2", mem_req, 0);
        do_reset();

        // Retrigger and MAR reload while busy
        ld_mar_val(16'h5000);
        mem_access(1'b0, 2, 16'hA5A5, 1'b1);
        chk("poke_no_err", mem_err, 0);

        // Reset aborts an access in flight
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        chk("abort_req_before", mem_req, 1);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h7777;
        tick();
        reset = 1'b0; mem_ack = 1'b0;
        chk("abort_req", mem_req, 0);
        chk("abort_done", mem_done, 0);
        chk("abort_busy", mem_busy, 0);
        chk("abort_mdr", mdr_out, 0);
        tick();
        chk("abort_done2", mem_done, 0);
        do_reset();

        // PC wrap and hold
        put_mdr(16'hFFFF);
        gate_sel = 3'd4; pc_sel = 2'd1; ld_pc = 1'b1;
        tick();
        clr();
        chk("pc_ffff", pc_out, 16'hFFFF);
        pc_sel = 2'd0; ld_pc = 1'b1;
        tick();
        clr();
        chk("pc_wrap", pc_out, 16'h0000);
        pc_sel = 2'd3; ld_pc = 1'b1;
        tick();
        clr();
        chk("pc_hold", pc_out, 16'h0000);
        m_pc = 16'h0000;

        // Branch enable
        ld_ir_val(16'h0A05);
        gate_sel = 3'd0; ld_cc = 1'b1;
        tick();
        clr();
        chk("cc_zero", cc_out, 3'b010);
        chk("ben_off", ben, 0);
        put_mdr(16'h8000);
        gate_sel = 3'd4; ld_cc = 1'b1;
        tick();
        clr();
        chk("cc_neg", cc_out, 3'b100);
        chk("ben_on", ben, 1);
        m_cc = 3'b100;
        for (int g = 5; g < 8; g++) begin
            gate_sel = 3'(g);
            #1;
            chk("bus_none", bus_out, 0);
        end
        clr();

        // Randomized register/ALU, address adder and memory traffic
        for (int i = 0; i < 8; i++) set_reg(i, 16'($urandom));
        for (int it = 0; it < 24; it++) begin
            logic [15:0] ir_v, exp_a, off;
            logic [1:0]  op, a2;
            logic        a1, s1, lp;
            ir_v = 16'($urandom);
            op = 2'($urandom_range(0, 3));
            ld_ir_val(ir_v);
            alu_exec(op);
            chk("rand_ben", ben, (m_ir[11:9] & m_cc) != 3'b000);

            a1 = 1'($urandom); a2 = 2'($urandom); s1 = 1'($urandom); lp = 1'($urandom);
            case (a2)
                2'd0:    off = 16'h0;
                2'd1:    off = sx(m_ir, 6);
                2'd2:    off = sx(m_ir, 9);
                default: off = sx(m_ir, 11);
            endcase
            exp_a = (a1 ? m_r[s1 ? m_ir[11:9] : m_ir[8:6]] : m_pc) + off;
            gate_sel = 3'd2; addr1_sel = a1; addr2_sel = a2; sr1_sel = s1;
            pc_sel = 2'd2; ld_pc = lp;
            #1;
            chk("addr_bus", bus_out, exp_a);
            tick();
            clr();
            if (lp) m_pc = exp_a;
            chk("addr_pc", pc_out, m_pc);

            rd_reg(int'(ir_v[11:9]));
            mem_access(1'($urandom), $urandom_range(0, TO), 16'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/slc3_datapath_mem.md
Name: slc3_datapath_mem

Overview:
Parametrised next-generation SLC-3 datapath. It holds PC, IR, MAR, MDR, an 8-entry register file, condition codes and the branch-enable logic, all sharing one internal bus. Unlike the previous datapath, it contains a memory-access engine: a request/acknowledge handshake with wait states, a timeout and a sticky error. It sits between the control FSM, which drives the load/select strobes and waits on mem_done, and the memory subsystem.

Parameters:
WIDTH, 16, data/address width; must be >= 16; the instruction encoding always occupies IR[15:0].
RESET_PC, 16'h0000 (zero-extended to WIDTH), PC value after reset.
MEM_TIMEOUT, 64, maximum wait cycles for mem_ack before an error is flagged; must be >= 2.

Ports:
clk  in  1  system clock, all state updates on the rising edge
reset  in  1  synchronous, active-high reset
ld_pc, ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc  in  1 each  register load strobes
gate_sel  in  3  bus source: 0 none (bus=0), 1 PC, 2 address adder, 3 ALU, 4 MDR, 5-7 none (bus=0)
pc_sel  in  2  PC source: 0 PC+1, 1 bus, 2 address adder, 3 hold
addr1_sel  in  1  address adder A input: 0 PC, 1 SR1
addr2_sel  in  2  address adder B input: 0 zero, 1 sext(IR[5:0]), 2 sext(IR[8:0]), 3 sext(IR[10:0])
sr1_sel  in  1  SR1 index: 0 IR[8:6], 1 IR[11:9]
dr_sel  in  1  destination register: 0 IR[11:9], 1 R7
aluop  in  2  0 ADD, 1 AND, 2 NOT A, 3 PASS A
mem_rd, mem_wr  in  1 each  single-cycle memory start pulses
mem_req  out  1  memory request
mem_we  out  1  write enable, valid while mem_req=1
mem_addr  out  WIDTH  address latched at request start
mem_wdata  out  WIDTH  write data latched at request start
mem_rdata  in  WIDTH  read data, sampled when mem_ack=1
mem_ack  in  1  memory acknowledge
mem_busy  out  1  memory engine is not IDLE
mem_done  out  1  one-cycle pulse on successful completion
mem_err  out  1  sticky flag: timeout or illegal request
ir_out, pc_out, mar_out, mdr_out  out  WIDTH  register contents
bus_out  out  WIDTH  internal bus value
cc_out  out  3  condition codes {N,Z,P}
ben  out  1  branch enable

Behaviour:
- Reset values: PC=RESET_PC; IR=MAR=MDR=0; all registers R0-R7=0; CC=3'b010; memory engine IDLE.
- Memory outputs after reset: mem_req, mem_we, mem_busy, mem_done and mem_err are all 0; mem_addr and mem_wdata are 0.
- Reset asserted mid-transaction aborts the access immediately: mem_req=0 on the next cycle and no mem_done pulse.
- Bus: purely combinational mux selected by gate_sel.
- Address adder: A + B, result taken modulo 2^WIDTH.
- Sign extension: every IR offset field and imm5 is sign-extended to WIDTH.
- ALU B operand: sext(IR[4:0]) when IR[5]=1, otherwise SR2 (index IR[2:0]). ALU arithmetic wraps modulo 2^WIDTH.
- PC: loaded when ld_pc=1. PC+1 wraps from all-ones to 0. pc_sel=3 holds PC even when ld_pc=1.
- IR and MAR: load the bus value when their strobe is set.
- MDR: loads the bus value when ld_mdr=1. A read completion in the same cycle takes priority and loads mem_rdata instead.
- Register file: ld_reg writes the bus to the selected DR. Reads are combinational. A read of the register being written in the same cycle returns the old value.
- CC: when ld_cc=1, CC <= {bus[WIDTH-1], bus==0, !bus[WIDTH-1] && bus!=0}.
- ben = |(IR[11:9] & CC), combinational from the registered values.
- Memory engine states: IDLE, RD_WAIT, WR_WAIT.
  - In IDLE, a mem_rd pulse moves to RD_WAIT and a mem_wr pulse moves to WR_WAIT. In both cases MAR is latched into mem_addr and MDR into mem_wdata. mem_req=1 from the following cycle; mem_we=1 only in WR_WAIT.
  - In a WAIT state, mem_ack=1 completes the access. On a read, MDR <= mem_rdata in that cycle. Next cycle: state IDLE, mem_req=0, mem_done=1 for exactly one cycle.
  - Minimum latency is 2 cycles from the start pulse to mem_done, when mem_ack is high on the first request cycle.
  - A wait counter clears on entry to a WAIT state and increments each request cycle without ack. When it reaches MEM_TIMEOUT: mem_err <= 1, return to IDLE, mem_req=0, no mem_done, MDR unchanged.
  - mem_rd and mem_wr both high in IDLE: neither access starts, mem_err <= 1.
  - mem_rd or mem_wr while busy: ignored, no error.
  - ld_mar or ld_mdr while busy updates the register; mem_addr and mem_wdata keep their latched values.
  - mem_ack while IDLE is ignored.
  - mem_err clears only on reset.

Test Plan:
- Reset, then check registers and memory outputs -> PC=RESET_PC, CC=010, mem_req=0, mem_err=0, all registers 0.
- R1=5; IR=16'h1262 (ADD R1,R1,#2); gate ALU, ld_reg, ld_cc -> R1=7, CC=001. Then IR=16'h127F (ADD R1,R1,#-1) -> R1=6.
- MAR=16'h3000; mem_rd pulse; mem_ack held 0 for 3 cycles, then 1 with mem_rdata=16'hBEEF -> mem_addr=3000 throughout, MDR=BEEF, mem_done pulses exactly once, 5 cycles after the start pulse.
- mem_wr with MDR=16'h1234, MAR=16'h4000, mem_ack never asserted, MEM_TIMEOUT=4 -> mem_req high for 4 cycles then low, mem_err=1, no mem_done; a following reset clears mem_err.
- mem_rd and mem_wr asserted together in IDLE -> no mem_req, mem_err=1. Separately, a second mem_rd while busy is ignored and exactly one mem_done follows.
- PC=16'hFFFF, pc_sel=0, ld_pc -> PC=0. IR=16'h0A05 (BRnp) with CC=010 -> ben=0; after loading bus=16'h8000 with ld_cc -> CC=100, ben=1.
